// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory helper between an IF read port and an LS read/write port.
// One transaction is in flight at a time: grant and issue happen in IDLE, and the response pulses in RESP.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_wen,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [DATA_W-1:0] ls_req_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic              mem_r_enable,
  output logic [63:0]       mem_r_index,
  input  logic [63:0]       mem_r_data,
  output logic              mem_w_enable,
  output logic [63:0]       mem_w_index,
  output logic [63:0]       mem_w_data,
  output logic [63:0]       mem_w_mask,
  output logic              dbg_state
);

  // Handshake: a request transfers in a cycle where valid && ready. Ready is combinational
  // and is offered only in IDLE, so a requester holds its request fields stable while valid
  // is high. Responses are single-cycle pulses with no backpressure.
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state;
  logic             owner_ls;
  logic             was_write;
  logic [CNT_W-1:0] starve_cnt;

  logic              grant_if;
  logic              grant_ls;
  logic              ls_rd;
  logic [ADDR_W-1:0] if_word;
  logic [ADDR_W-1:0] ls_word;

  assign if_word = if_req_addr >> 3;
  assign ls_word = ls_req_addr >> 3;

  // Grants are gated by reset_n so that nothing is accepted while reset is held.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (reset_n && state == IDLE) begin
      if (ls_req_valid && !(if_req_valid && starve_cnt == STARVE_LIM)) begin
        grant_ls = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  assign ls_rd        = grant_ls && !ls_req_wen;
  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  assign mem_r_enable = grant_if || ls_rd;
  assign mem_r_index  = grant_if ? 64'(if_word) : (ls_rd ? 64'(ls_word) : 64'd0);
  assign mem_w_enable = grant_ls && ls_req_wen;
  assign mem_w_index  = mem_w_enable ? 64'(ls_word) : 64'd0;
  assign mem_w_data   = mem_w_enable ? 64'(ls_req_wdata) : 64'd0;
  assign mem_w_mask   = mem_w_enable ? 64'(ls_req_wmask) : 64'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner_ls   <= 1'b1;
      was_write  <= 1'b0;
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_ls || grant_if) begin
        state     <= RESP;
        owner_ls  <= grant_ls;
        was_write <= grant_ls && ls_req_wen;
      end
      // Count IF losses only while IF is actually waiting; an IF win resets the count.
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_ls && if_req_valid && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      state <= IDLE;
    end
  end

  assign if_resp_valid = (state == RESP) && !owner_ls;
  assign ls_resp_valid = (state == RESP) && owner_ls;
  assign if_resp_data  = if_resp_valid ? DATA_W'(mem_r_data) : '0;
  assign ls_resp_data  = (ls_resp_valid && !was_write) ? DATA_W'(mem_r_data) : '0;
  assign dbg_state     = (state == RESP);

endmodule
